fifo_mrp_sync: RTL and testbench

//  Single-writer FIFO with NUM_RD independent read ports; each port keeps its own read pointer and consumes every entry.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mrp_sync_if.sv | 28 ++
 rtl/fifo_rd_port.sv | 62 ++++++
 rtl/fifo_mrp_sync.sv | 95 +++++++++
 tb/tb_fifo_mrp_sync.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the multi-read-port FIFO.
// Optional FIFO_ERR_EN macro (see fifo_mrp_sync.sv) adds sticky error flags.
package fifo_pkg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Occupancy at which a read port is full (DEPTH = 2**addr_width).
    function automatic int full_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int EMPTY_DEPTH = 0;

endpackage

// File: rtl/fifo_mrp_sync_if.sv
// Producer/consumer bundle for fifo_mrp_sync.
// With FIFO_ERR_EN defined the bundle also carries the sticky error flags.
interface fifo_mrp_sync_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_RD     = 2
);
    logic                         w_en;
    logic [DATA_WIDTH-1:0]        data_in;
    logic [NUM_RD-1:0]            r_en;
    logic [NUM_RD*DATA_WIDTH-1:0] data_out;
    logic [NUM_RD-1:0]            r_valid;
    logic                         n_full;
    logic [NUM_RD-1:0]            n_empty;
`ifdef FIFO_ERR_EN
    logic                         err_ovf;
    logic [NUM_RD-1:0]            err_udf;

    modport master (output w_en, data_in, r_en,
                    input  data_out, r_valid, n_full, n_empty, err_ovf, err_udf);
    modport slave  (input  w_en, data_in, r_en,
                    output data_out, r_valid, n_full, n_empty, err_ovf, err_udf);
`else
    modport master (output w_en, data_in, r_en,
                    input  data_out, r_valid, n_full, n_empty);
    modport slave  (input  w_en, data_in, r_en,
                    output data_out, r_valid, n_full, n_empty);
`endif
endinterface

// File: rtl/fifo_rd_port.sv
// One independent read port: own pointer, occupancy, registered read data.
// With FIFO_ERR_EN defined it also keeps a sticky underflow flag.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ptr_width(ADDR_WIDTH)-1:0] w_ptr,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        rd_data,
    output logic [ADDR_WIDTH-1:0]        r_addr,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         r_valid,
    output logic                         n_empty,
    output logic                         at_full
`ifdef FIFO_ERR_EN
    ,
    output logic                         err_udf
`endif
);
    localparam int                PTR_W    = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0]  FULL_LVL = PTR_W'(full_depth(ADDR_WIDTH));
    localparam logic [PTR_W-1:0]  EMPTY_LVL = PTR_W'(EMPTY_DEPTH);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] depth;
    logic             r_acc;

    // Flags come from registered pointers only, so no request feeds back into them.
    assign depth   = w_ptr - r_ptr;
    assign n_empty = (depth != EMPTY_LVL);
    assign at_full = (depth == FULL_LVL);
    assign r_acc   = r_en & n_empty;
    assign r_addr  = r_ptr[ADDR_WIDTH-1:0];

    // Pop on an accepted read; data_out holds its value otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr    <= '0;
            data_out <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= r_acc;
            if (r_acc) begin
                data_out <= rd_data;
                r_ptr    <= r_ptr + 1'b1;
            end
        end
    end

`ifdef FIFO_ERR_EN
    // Sticky underflow: a read requested while this port had nothing to give.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               err_udf <= 1'b0;
        else if (r_en && !n_empty)  err_udf <= 1'b1;
    end
`endif

endmodule

// File: rtl/fifo_mrp_sync.sv
// Single-writer FIFO broadcasting every entry to NUM_RD independent readers.
// Optional feature macro: FIFO_ERR_EN adds sticky err_ovf / err_udf flags.
module fifo_mrp_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    fifo_mrp_sync_if.slave   bus
);
    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = full_depth(ADDR_WIDTH);

    logic [PTR_W-1:0]      w_ptr;
    logic                  w_acc;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_addr   [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_data  [NUM_RD];
    logic [DATA_WIDTH-1:0] port_out [NUM_RD];
    logic [NUM_RD-1:0]     r_valid;
    logic [NUM_RD-1:0]     n_empty;
    logic [NUM_RD-1:0]     at_full;
`ifdef FIFO_ERR_EN
    logic [NUM_RD-1:0]     err_udf;
`endif

    // The slowest reader decides fullness; pre-cycle flags gate the write.
    assign bus.n_full = ~|at_full;
    assign w_acc      = bus.w_en & bus.n_full;

    // Write pointer advances on every accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) w_ptr <= '0;
        else if (w_acc) w_ptr <= w_ptr + 1'b1;
    end

    // Storage write.
    // NOTE: the array has no reset; contents are only ever read behind valid pointers.
    always_ff @(posedge clk) begin
        if (w_acc) mem[w_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            assign rd_data[gi] = mem[r_addr[gi]];

            fifo_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_port (
                .clk      (clk),
                .reset_n  (reset_n),
                .w_ptr    (w_ptr),
                .r_en     (bus.r_en[gi]),
                .rd_data  (rd_data[gi]),
                .r_addr   (r_addr[gi]),
                .data_out (port_out[gi]),
                .r_valid  (r_valid[gi]),
                .n_empty  (n_empty[gi]),
                .at_full  (at_full[gi])
`ifdef FIFO_ERR_EN
                ,
                .err_udf  (err_udf[gi])
`endif
            );
        end
    endgenerate

    // Pack per-port results onto the flat bus.
    always_comb begin
        bus.data_out = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.data_out[i*DATA_WIDTH +: DATA_WIDTH] = port_out[i];
        end
    end

    assign bus.r_valid = r_valid;
    assign bus.n_empty = n_empty;

`ifdef FIFO_ERR_EN
    assign bus.err_udf = err_udf;

    // Sticky overflow: a write requested while some reader was full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    bus.err_ovf <= 1'b0;
        else if (bus.w_en && !bus.n_full) bus.err_ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_mrp_sync.sv
// Scoreboard bench for fifo_mrp_sync (NUM_RD=2, ADDR_WIDTH=2, DATA_WIDTH=16).
// Honours FIFO_ERR_EN when defined.
module tb_fifo_mrp_sync;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int NR = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    fifo_mrp_sync_if #(.DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

    fifo_mrp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: every accepted write, and how far each reader has consumed.
    logic [DW-1:0] written[$];
    int            wcnt;
    int            rcnt[NR];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic          m_ovf;
    logic [NR-1:0] m_udf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        written.delete();
        exp_q0.delete();
        exp_q1.delete();
        wcnt = 0;
        for (int i = 0; i < NR; i++) rcnt[i] = 0;
        m_ovf = 1'b0;
        m_udf = '0;
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic [NR-1:0] r);
        logic          nf;
        logic [NR-1:0] ne;
        nf = 1'b1;
        for (int i = 0; i < NR; i++) begin
            int occ;
            occ   = wcnt - rcnt[i];
            ne[i] = (occ != 0);
            if (occ == DEPTH) nf = 1'b0;
        end
        check("n_full", bus.n_full, nf);
        check("n_empty", bus.n_empty, ne);
        bus.w_en = w; bus.data_in = d; bus.r_en = r;
        for (int i = 0; i < NR; i++) begin
            if (r[i] && ne[i]) begin
                if (i == 0) exp_q0.push_back(written[rcnt[i]]);
                else        exp_q1.push_back(written[rcnt[i]]);
                rcnt[i]++;
            end
            if (r[i] && !ne[i]) m_udf[i] = 1'b1;
        end
        if (w && nf) begin
            written.push_back(d);
            wcnt++;
        end
        if (w && !nf) m_ovf = 1'b1;
        @(posedge clk); #1;
        bus.w_en = 1'b0; bus.r_en = '0;
`ifdef FIFO_ERR_EN
        check("err_ovf", bus.err_ovf, m_ovf);
        check("err_udf", bus.err_udf, m_udf);
`endif
    endtask

    // Asynchronous reset mid-cycle; flags must drop before any clock edge.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_n_empty"}, bus.n_empty, 2'b00);
        check({tag, "_n_full"},  bus.n_full, 1'b1);
        check({tag, "_r_valid"}, bus.r_valid, 2'b00);
        check({tag, "_data_out"}, bus.data_out, 32'h0);
        model_clear();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Monitor: every valid read beat is popped from that port's expectation queue.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.r_valid[i]) begin
                    logic [DW-1:0] got;
                    got = bus.data_out[i*DW +: DW];
                    if (i == 0) begin
                        if (exp_q0.size() == 0) check("rd0_unexpected", 1, 0);
                        else check("rd0_data", got, exp_q0.pop_front());
                    end else begin
                        if (exp_q1.size() == 0) check("rd1_unexpected", 1, 0);
                        else check("rd1_data", got, exp_q1.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_en = 1'b0; bus.data_in = '0; bus.r_en = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state, then a read request on an empty FIFO.
        check("rst_n_full", bus.n_full, 1'b1);
        check("rst_n_empty", bus.n_empty, 2'b00);
        check("rst_r_valid", bus.r_valid, 2'b00);
        check("rst_data_out", bus.data_out, 32'h0);
        step(1'b0, 16'h0, 2'b11);
        check("empty_rd_r_valid", bus.r_valid, 2'b00);
        check("empty_rd_n_empty", bus.n_empty, 2'b00);

        // Fill to full; the fifth write is dropped.
        for (int k = 0; k < 4; k++) step(1'b1, 16'hA0 + 16'(k), 2'b00);
        check("fill_n_full", bus.n_full, 1'b0);
        step(1'b1, 16'hA4, 2'b00);
`ifdef FIFO_ERR_EN
        check("fill_err_ovf", bus.err_ovf, 1'b1);
`endif
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 2'b01);

        // Skew: port0 drained, port1 untouched keeps the FIFO full.
        check("skew_n_full", bus.n_full, 1'b0);
        check("skew_n_empty", bus.n_empty, 2'b10);
        step(1'b0, 16'h0, 2'b10);
        check("skew_release", bus.n_full, 1'b1);
        step(1'b1, 16'hB0, 2'b00);
        check("skew_port0_ne", bus.n_empty[0], 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 2'b11);

        // Simultaneous write and reads while full: write refused this cycle.
        async_reset("sim_rst");
        for (int k = 0; k < 4; k++) step(1'b1, 16'hA0 + 16'(k), 2'b00);
        step(1'b1, 16'hC0, 2'b11);
        check("sim_rd0", bus.data_out[15:0], 16'hA0);
        check("sim_rd1", bus.data_out[31:16], 16'hA0);
        check("sim_n_full", bus.n_full, 1'b1);
        step(1'b1, 16'hC0, 2'b00);
        check("sim_wr_accepted", bus.n_full, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 2'b11);
        check("sim_drained", bus.n_empty, 2'b00);

        // Wrap: 20 write/read pairs, pointers run well past 7.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 16'(k), 2'b00);
            step(1'b0, 16'h0, 2'b11);
        end
        check("wrap_count", wcnt, 25);

        // Reset mid-stream with three entries buffered.
        for (int k = 0; k < 3; k++) step(1'b1, 16'hD0 + 16'(k), 2'b00);
        check("mid_n_empty_before", bus.n_empty, 2'b11);
        async_reset("mid_rst");
        step(1'b0, 16'h0, 2'b11);
        check("post_rst_r_valid", bus.r_valid, 2'b00);

        @(posedge clk); #1;
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
